// File: rtl/sim_ctrl_pkg.sv
// Shared definitions for the MIPS run/reset sequencer.
// Holds the controller state encoding, the default exit syscall code and the
// register index that carries the syscall code ($v0).
package sim_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RESET_HOLD = 3'd1,
    ST_RUN        = 3'd2,
    ST_HALTED     = 3'd3,
    ST_TIMEOUT    = 3'd4
  } state_e;

  localparam logic [31:0] DEFAULT_EXIT_CODE = 32'd10;
  localparam logic [4:0]  V0_REG_IDX        = 5'd2;

  // True when an executed syscall requests program exit.
  function automatic logic is_exit_syscall(input logic        valid,
                                           input logic [31:0] code,
                                           input logic [31:0] exit_code);
    return valid && (code == exit_code);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Enable/clear counter with a terminal-value compare.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear (wins over enable)
//   en_i          : increment this cycle
//   term_i        : terminal value to compare against
//   count_o       : registered count (wraps modulo 2^CNT_W)
//   hit_o         : this increment lands exactly on term_i
module sat_counter
  import sim_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic [CNT_W-1:0] count_o,
  output logic             hit_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] next_s;

  assign next_s = count_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next count: clear, increment or hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = next_s;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Hit is judged on the incremented value so the caller can act in the
  // same cycle the terminal value is reached.
  assign hit_o   = en_i && !clr_i && (next_s == term_i);
  assign count_o = count_q;

endmodule

// File: rtl/sim_run_controller.sv
// Run/reset sequencer for the MIPS TopLevel core.
// Holds the core in reset for RESET_CYCLES clock-enabled cycles, then lets it
// run free or one cycle per step request, counting enabled cycles and retired
// instructions until an exit syscall (HALTED) or budget exhaustion (TIMEOUT).
// Ports:
//   clock, reset          : clock, asynchronous active-low reset
//   start                 : begin/restart a run (IDLE, HALTED, TIMEOUT only)
//   mode_step, step_req   : single-step mode select and step pulse
//   retire_valid          : core retired an instruction
//   syscall_valid/_code   : core executed a syscall with $v0 = code
//   core_reset/core_clk_en: reset and clock-enable driven to the core
//   state                 : FSM state encoding
//   cycle_count           : enabled run cycles since start
//   retired_count         : retired instructions since start
//   done, timed_out       : sticky run-end flags
// All outputs come straight from registers.
module sim_run_controller
  import sim_ctrl_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int          RESET_CYCLES = 1,
  parameter int unsigned MAX_CYCLES   = 200000,
  parameter logic [31:0] EXIT_CODE    = DEFAULT_EXIT_CODE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode_step,
  input  logic             step_req,
  input  logic             retire_valid,
  input  logic             syscall_valid,
  input  logic [31:0]      syscall_code,
  output logic             core_reset,
  output logic             core_clk_en,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count,
  output logic             done,
  output logic             timed_out
);

  localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              core_reset_q, core_reset_d;
  logic              clk_en_q, clk_en_d;
  logic              done_q, done_d;
  logic              timed_out_q, timed_out_d;

  logic              clr_s;
  logic              cyc_en_s;
  logic              ret_en_s;
  logic              cyc_hit_s;
  logic              budget_hit_s;
  logic              exit_s;
  logic              retire_hit_unused_s;

  // Core inputs only matter on cycles the core actually saw a clock edge.
  assign cyc_en_s     = (state_q == ST_RUN) && clk_en_q;
  assign ret_en_s     = cyc_en_s && retire_valid;
  assign exit_s       = is_exit_syscall(syscall_valid, syscall_code, EXIT_CODE);
  assign budget_hit_s = (MAX_CYCLES != 32'd0) && cyc_hit_s;

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk_i  (clock),
    .rst_ni (reset),
    .clr_i  (clr_s),
    .en_i   (cyc_en_s),
    .term_i (CNT_W'(MAX_CYCLES)),
    .count_o(cycle_count),
    .hit_o  (cyc_hit_s)
  );

  sat_counter #(.CNT_W(CNT_W)) u_retired_cnt (
    .clk_i  (clock),
    .rst_ni (reset),
    .clr_i  (clr_s),
    .en_i   (ret_en_s),
    .term_i ({CNT_W{1'b0}}),
    .count_o(retired_count),
    .hit_o  (retire_hit_unused_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    core_reset_d = core_reset_q;
    clk_en_d     = 1'b0;
    done_d       = done_q;
    timed_out_d  = timed_out_q;
    clr_s        = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
        if (start) begin
          state_d      = ST_RESET_HOLD;
          hold_d       = HOLD_W'(RESET_CYCLES);
          core_reset_d = 1'b1;
          clk_en_d     = 1'b1;
          done_d       = 1'b0;
          timed_out_d  = 1'b0;
          clr_s        = 1'b1;
        end else begin
          state_d = state_q;
        end
      end

      ST_RESET_HOLD: begin
        // The core is clocked while in reset so it can settle its state.
        core_reset_d = 1'b1;
        clk_en_d     = 1'b1;
        if (hold_q == HOLD_W'(1)) begin
          state_d      = ST_RUN;
          core_reset_d = 1'b0;
          clk_en_d     = !mode_step || step_req;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end

      ST_RUN: begin
        core_reset_d = 1'b0;
        // In step mode each sampled step_req buys exactly one enabled cycle.
        clk_en_d     = !mode_step || step_req;
        if (cyc_en_s && exit_s) begin
          // Exit wins over a budget hit in the same cycle.
          state_d  = ST_HALTED;
          done_d   = 1'b1;
          clk_en_d = 1'b0;
        end else if (budget_hit_s) begin
          state_d     = ST_TIMEOUT;
          timed_out_d = 1'b1;
          clk_en_d    = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        core_reset_d = 1'b1;
      end
    endcase
  end

  // Controller state and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      core_reset_q <= 1'b1;
      clk_en_q     <= 1'b0;
      done_q       <= 1'b0;
      timed_out_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      core_reset_q <= core_reset_d;
      clk_en_q     <= clk_en_d;
      done_q       <= done_d;
      timed_out_q  <= timed_out_d;
    end
  end

  assign state       = state_q;
  assign core_reset  = core_reset_q;
  assign core_clk_en = clk_en_q;
  assign done        = done_q;
  assign timed_out   = timed_out_q;

endmodule

// File: doc/sim_run_controller.md
Name: sim_run_controller

Overview:
- Synthesizable run/reset sequencer for the MIPS `TopLevel` core. It replaces hard-coded bench reset and clock loops.
- Holds the core in reset for a parametrised number of cycles, then runs it free-running or in single-step mode.
- Counts cycles and retired instructions; ends the run on an exit syscall or on a cycle-budget timeout.
- Sits between the bench/host and `TopLevel`, gating the core via a clock-enable.

Parameters:
- CNT_W, 32, width of the cycle and retired-instruction counters.
- RESET_CYCLES, 1, cycles `core_reset` is held in RESET_HOLD (≥1).
- MAX_CYCLES, 200000, run-cycle budget; 0 disables the timeout.
- EXIT_CODE, 10, syscall code ($v0 value) that terminates the run.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  single-cycle pulse: begin or restart a run.
- mode_step  in  1  1 = single-step mode, 0 = free-run.
- step_req  in  1  single-cycle pulse: advance the core one cycle (step mode only).
- retire_valid  in  1  core retired one instruction this cycle.
- syscall_valid  in  1  core executed a syscall this cycle.
- syscall_code  in  32  $v0 value accompanying `syscall_valid`.
- core_reset  out  1  active-high reset to `TopLevel`.
- core_clk_en  out  1  clock-enable to `TopLevel`.
- state  out  3  current FSM state encoding.
- cycle_count  out  CNT_W  enabled run cycles since start.
- retired_count  out  CNT_W  instructions retired since start.
- done  out  1  run ended by exit syscall (sticky).
- timed_out  out  1  run ended by budget exhaustion (sticky).

Behaviour:
- Async reset (reset=0):
  - state=IDLE, core_reset=1, core_clk_en=0.
  - cycle_count=0, retired_count=0, done=0, timed_out=0.
  - Deassertion takes effect at the next rising edge.
- All outputs are registered (Moore). No combinational input-to-output paths.
- States: IDLE=0, RESET_HOLD=1, RUN=2, HALTED=3, TIMEOUT=4.
- IDLE:
  - core_reset=1, core_clk_en=0.
  - start → RESET_HOLD: load hold counter with RESET_CYCLES; clear both counters, done and timed_out.
- RESET_HOLD:
  - core_reset=1, core_clk_en=1, so the core sees clock edges while in reset.
  - Occupies exactly RESET_CYCLES cycles, then → RUN. Entering RUN drops core_reset to 0.
  - start is ignored.
- RUN, free mode (mode_step=0): core_clk_en=1 every cycle.
- RUN, step mode (mode_step=1):
  - core_clk_en=0 except one cycle after each sampled step_req (latency 1).
  - step_req arriving in the same cycle core_clk_en is high still yields exactly one further enabled cycle; step_reqs are not queued beyond one.
  - A mode_step change takes effect the following cycle.
- RUN counting and exits (all qualified by core_clk_en=1):
  - cycle_count increments on each enabled cycle.
  - retired_count increments when retire_valid=1.
  - syscall_valid=1 with syscall_code==EXIT_CODE → HALTED, done=1.
  - Other syscall codes are ignored.
  - If MAX_CYCLES≠0 and cycle_count reaches MAX_CYCLES on this increment → TIMEOUT, timed_out=1.
  - Exit syscall and budget exhaustion in the same cycle → HALTED only. done=1, timed_out=0, cycle_count still incremented.
  - start is ignored in RUN.
- HALTED / TIMEOUT:
  - core_clk_en=0, core_reset=0.
  - Counters are frozen; done/timed_out are held.
  - start → RESET_HOLD (restart as from IDLE).
- Counters wrap modulo 2^CNT_W when MAX_CYCLES=0. MAX_CYCLES must be < 2^CNT_W.
- Inputs are ignored while core_clk_en=0, except start, step_req and mode_step.
- reset=0 mid-RUN: immediate return to reset values; core_reset rises asynchronously.

Decomposition:
- Shared package `sim_ctrl_pkg`:
  - state enum/localparams (IDLE..TIMEOUT).
  - default EXIT_CODE (10) and the $v0 register index.
- One sub-module, `sat_counter` (CNT_W, enable, clear, terminal-value compare), instanced for the cycle count and the retired count. The hold counter is inline.

Test Plan:
- Reset: reset=0 for 3 cycles, then release → state=0, core_reset=1, core_clk_en=0, all counts 0, done=0, timed_out=0.
- RESET_CYCLES=3, start at cycle 5 → core_reset=1 and core_clk_en=1 for exactly 3 cycles; state=2 and core_reset=0 from the 4th cycle after start.
- Free run: retire_valid every cycle; at enabled cycle 50, syscall_valid=1 with code 10 → done=1, state=3, cycle_count=50, retired_count=50, core_clk_en=0 next cycle.
- Timeout: MAX_CYCLES=100, no exit syscall → timed_out=1, state=4, cycle_count=100. A syscall with code 4 at cycle 40 has no effect.
- Step mode: 5 step_req pulses spaced 4 cycles apart → exactly 5 single-cycle core_clk_en pulses, each 1 cycle after its step_req; cycle_count=5.
- Simultaneous exit and budget: MAX_CYCLES=20, exit syscall at enabled cycle 20 → HALTED, done=1, timed_out=0.
- Restart: start in HALTED → RESET_HOLD, counts and done cleared.
- Reset mid-RUN: reset=0 mid-run → core_reset=1 immediately, without waiting for a clock edge.
